// File: rtl/capture_tx_sequencer.sv
// Capture/transmit sequencer: fills a 2**AddrWidth buffer from an ADC, then streams it out.
// Define SEQ_CONTINUOUS_EN to restart a new run straight after DONE instead of returning to IDLE.
module capture_tx_sequencer #(
    parameter int AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 adc_start_o,
    input  logic                 adc_done_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 tx_start_o,
    input  logic                 tx_busy_i,
    output logic                 tx_phase_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [3:0]           state_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CONV_REQ = 4'd1,
        WAIT_ADC = 4'd2,
        WRITE    = 4'd3,
        TX_REQ   = 4'd4,
        TX_ACK   = 4'd5,
        TX_WAIT  = 4'd6,
        TX_NEXT  = 4'd7,
        DONE     = 4'd8
    } state_e;

    localparam logic [AddrWidth-1:0] LastAddr = '1;
    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 tx_start_q, tx_start_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_start_q <= tx_start_d;
        end
    end

    // tx_start is registered so the launch pulse lands in the first TX_ACK cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_start_d = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d = '0;
                    if (start_i) state_d = CONV_REQ;
                end
                CONV_REQ: state_d = WAIT_ADC;
                WAIT_ADC: if (adc_done_i) state_d = WRITE;
                WRITE: begin
                    if (addr_q == LastAddr) begin
                        addr_d  = '0;
                        state_d = TX_REQ;
                    end else begin
                        addr_d  = addr_q + AddrOne;
                        state_d = CONV_REQ;
                    end
                end
                TX_REQ: begin
                    if (!tx_busy_i) begin
                        tx_start_d = 1'b1;
                        state_d    = TX_ACK;
                    end
                end
                TX_ACK:  if (tx_busy_i) state_d = TX_WAIT;
                TX_WAIT: if (!tx_busy_i) state_d = TX_NEXT;
                TX_NEXT: begin
                    if (addr_q == LastAddr) begin
                        addr_d  = '0;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + AddrOne;
                        state_d = TX_REQ;
                    end
                end
`ifdef SEQ_CONTINUOUS_EN
                DONE: state_d = CONV_REQ;
`else
                DONE: state_d = IDLE;
`endif
                default: begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        adc_start_o = (state_q == CONV_REQ);
        we_o        = (state_q == WRITE);
        tx_start_o  = tx_start_q;
        tx_phase_o  = (state_q == TX_REQ) || (state_q == TX_ACK) ||
                      (state_q == TX_WAIT) || (state_q == TX_NEXT);
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        addr_o      = addr_q;
        state_o     = state_q;
    end

endmodule

// File: tb/tb_capture_tx_sequencer.sv
// Bench for capture_tx_sequencer: ADC and transmitter responders plus an event scoreboard.
// Honours SEQ_CONTINUOUS_EN the same way the design does.
module tb_capture_tx_sequencer;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_ADC = 4'd2;
    localparam logic [3:0] S_TX_REQ   = 4'd4;
    localparam logic [3:0] S_TX_WAIT  = 4'd6;
    localparam logic [1:0] EV_WE = 2'd1, EV_TX = 2'd2, EV_DONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0, abort_i = 1'b0;
    logic          adc_start_o, we_o, tx_start_o, tx_phase_o, busy_o, done_o;
    logic [AW-1:0] addr_o;
    logic [3:0]    state_o;
    logic          adc_done_i, tx_busy_i;

    // Responder outputs, with manual overrides for directed scenarios
    logic adc_auto = 1'b1, adc_done_auto = 1'b0, adc_done_man = 1'b0;
    logic tx_auto = 1'b1, tx_busy_auto = 1'b0, tx_busy_man = 1'b0;
    assign adc_done_i = adc_auto ? adc_done_auto : adc_done_man;
    assign tx_busy_i  = tx_auto ? tx_busy_auto : tx_busy_man;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    logic [AW+1:0] exp_q[$];

    capture_tx_sequencer #(.AddrWidth(AW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .adc_start_o(adc_start_o), .adc_done_i(adc_done_i), .we_o(we_o),
        .addr_o(addr_o), .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i),
        .tx_phase_o(tx_phase_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic [AW+1:0] ev);
        if (exp_q.size() == 0) check("sb_extra", 32'(exp_q.size()), 32'd1);
        else                   check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
    endtask

    task automatic push_run(input int n_we, input int n_tx, input bit with_done);
        for (int i = 0; i < n_we; i++) exp_q.push_back({EV_WE, AW'(i)});
        for (int i = 0; i < n_tx; i++) exp_q.push_back({EV_TX, AW'(i)});
        if (with_done) exp_q.push_back({EV_DONE, {AW{1'b0}}});
    endtask

    // ADC answers 3 cycles after adc_start_o; transmitter stays busy 10 cycles per word
    initial begin
        int adc_cnt = 0;
        int tx_cnt = 0;
        forever begin
            @(negedge clk);
            adc_done_auto = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) adc_done_auto = 1'b1;
            end
            if (adc_start_o) adc_cnt = 3;
            if (tx_cnt > 0) tx_cnt--;
            tx_busy_auto = (tx_cnt > 0);
            if (tx_start_o) begin
                tx_cnt = 10;
                tx_busy_auto = 1'b1;
            end
        end
    end

    logic adc_done_prev = 1'b0;
    always @(negedge clk) begin
        if (we_o) begin
            sb_pop({EV_WE, addr_o});
            check("we_latency", 32'(adc_done_prev), 32'd1);
            check("we_phase", 32'(tx_phase_o), 32'd0);
        end
        if (tx_start_o) begin
            sb_pop({EV_TX, addr_o});
            check("tx_phase", 32'(tx_phase_o), 32'd1);
        end
        if (done_o) begin
            done_seen++;
            sb_pop({EV_DONE, {AW{1'b0}}});
        end
        adc_done_prev = adc_done_i;
    end

    task automatic wait_state(input logic [3:0] st, input logic [AW-1:0] a, input string tag);
        int i = 0;
        while (i < 3000 && !(state_o == st && addr_o == a)) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'({state_o, addr_o}), 32'({st, a}));
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (i < 3000 && !done_o) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(done_o), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(S_IDLE));
        check({tag, "_addr"}, 32'(addr_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic settle();
        repeat (15) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("lat_adc_start", 32'(adc_start_o), 32'd1);
        check("lat_addr", 32'(addr_o), 32'd0);
    endtask

    task automatic finish_run(input string tag);
        wait_done({tag, "_done"});
        @(negedge clk);
`ifdef SEQ_CONTINUOUS_EN
        check({tag, "_restart"}, 32'(adc_start_o), 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
`else
        check({tag, "_no_restart"}, 32'(adc_start_o), 32'd0);
`endif
        check_idle(tag);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        settle();
    endtask

    initial begin
        int cnt;
        int done_before;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("rst");
        check("rst_pulses", 32'({adc_start_o, we_o, tx_start_o, done_o, tx_phase_o}), 32'd0);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_hold");

        // Full capture and transmit run
        push_run(DEPTH, DEPTH, 1'b1);
        pulse_start();
        finish_run("run");

        // Transmitter stalled while the FSM enters TX_REQ
        push_run(DEPTH, DEPTH, 1'b1);
        tx_busy_man = 1'b1;
        tx_auto = 1'b0;
        pulse_start();
        wait_state(S_TX_REQ, '0, "stall_reach");
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start_o) cnt++;
        end
        check("stall_no_start", 32'(cnt), 32'd0);
        check("stall_state", 32'(state_o), 32'(S_TX_REQ));
        tx_busy_man = 1'b0;
        @(negedge clk);
        check("stall_release", 32'(tx_start_o), 32'd1);
        tx_auto = 1'b1;
        finish_run("stall");

        // Reset in WAIT_ADC at address 17, then a late adc_done
        push_run(17, 0, 1'b0);
        pulse_start();
        wait_state(S_WAIT_ADC, AW'(17), "rst_reach");
        adc_auto = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check_idle("midrst");
        adc_done_man = 1'b1;
        @(negedge clk);
        adc_done_man = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (we_o) cnt++;
            @(negedge clk);
        end
        check("midrst_no_we", 32'(cnt), 32'd0);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);
        adc_auto = 1'b1;
        settle();

        // Abort in TX_WAIT at address 5
        push_run(DEPTH, 6, 1'b0);
        done_before = done_seen;
        pulse_start();
        wait_state(S_TX_WAIT, AW'(5), "abort_reach");
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check_idle("abort");
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_seen - done_before), 32'd0);
        check("abort_drained", 32'(exp_q.size()), 32'd0);
        check_idle("abort_later");

        // start and abort together in IDLE
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check_idle("start_abort");
        @(negedge clk);
        check("start_abort_no_adc", 32'(adc_start_o), 32'd0);
        check_idle("start_abort_later");

`ifdef SEQ_CONTINUOUS_EN
        // Three back-to-back runs from a single start
        push_run(DEPTH, DEPTH, 1'b1);
        push_run(DEPTH, DEPTH, 1'b1);
        push_run(DEPTH, DEPTH, 1'b1);
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            wait_done("cont_done");
            @(negedge clk);
            check("cont_restart", 32'(adc_start_o), 32'd1);
            check("cont_addr", 32'(addr_o), 32'd0);
        end
        finish_run("cont_last");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
